mainfsm_hs: RTL and testbench
=============================

Name: mainfsm_hs

Overview:
Parametrised successor to the multicycle main control FSM.
- Drives the same datapath control bundle (IRWrite, AdrSrc, ALUSrcA/B, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp) for data-processing (reg/imm), LDR/STR and B.
- Adds a memory request/ready handshake with wait states and a bounded timeout.
- Adds sticky fault reporting for timeout and illegal opcode.
- Sits inside the controller, between the instruction decoder and the condition-logic gating of RegW/MemW/NextPC.

Parameters:
- MEM_TIMEOUT, 15: max cycles a memory state waits for MemReady before faulting; 0 = wait forever.
- MUL_CYCLES, 2: execute-stage length for multiply; only used when MUL_EN is defined; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- Op  in  2  instr[27:26]
- Funct  in  6  instr[25:20]
- IsMul  in  1  decoded multiply indication (instr[7:4]==1001, Op==00)
- MemReady  in  1  memory completes the current request this cycle
- MemReq  out  1  memory access request
- IRWrite  out  1  load instruction register
- AdrSrc  out  1  0=PC, 1=ALUResult register
- ALUSrcA  out  2  ALU A select
- ALUSrcB  out  2  ALU B select
- ResultSrc  out  2  result mux select
- NextPC  out  1  PC write request
- RegW  out  1  register write request
- MemW  out  1  memory write request
- Branch  out  1  branch-state indication
- ALUOp  out  1  ALU decoder enable
- MulStart  out  1  one-cycle multiply start pulse
- Fault  out  2  sticky: 01 mem timeout, 10 illegal Op, 00 none
- State  out  4  current state, for debug

Behaviour:
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, EXECUTEM, ALUWB, BRANCH, FAULT.

Reset and state register:
- Registered on posedge clk; reset is synchronous and overrides everything.
- reset -> State=FETCH, wait counter=0, mul counter=0, Fault=00.
- Reset mid-access aborts the access: MemReq drops on the next cycle and no write commits.

Transitions:
- FETCH: -> DECODE when MemReady, else stay.
- DECODE:
  - Op=00: IsMul && MUL_EN -> EXECUTEM; else Funct[5] ? EXECUTEI : EXECUTER.
  - Op=01 -> MEMADR. Op=10 -> BRANCH. Op=11 -> FAULT with Fault=10.
- MEMADR: Funct[0] ? MEMREAD : MEMWRITE.
- MEMREAD: -> MEMWB when MemReady, else stay.
- MEMWRITE: -> FETCH when MemReady, else stay.
- MEMWB, ALUWB, BRANCH: -> FETCH.
- EXECUTER, EXECUTEI: -> ALUWB.
- EXECUTEM: -> ALUWB after exactly MUL_CYCLES cycles in the state.
- FAULT: absorbing until reset; all control outputs 0.

Wait counter:
- Width $clog2(MEM_TIMEOUT+1).
- Cleared on entry to FETCH, MEMREAD and MEMWRITE; increments each cycle in those states while MemReady=0.
- If MEM_TIMEOUT!=0 and the counter equals MEM_TIMEOUT while MemReady=0 -> FAULT with Fault=01.
- MemReady in that same cycle wins: no fault is raised.

Memory handshake:
- MemReq=1 in FETCH, MEMREAD and MEMWRITE only.
- A write commits on MemReq & MemW & MemReady.
- IRWrite and NextPC assert in FETCH only in the MemReady cycle, so the PC advances exactly once per fetch.

Controls per state (unlisted signals = 0):
- FETCH: ResultSrc=10, ALUSrcA=01, ALUSrcB=10, MemReq=1; IRWrite=NextPC=MemReady.
- DECODE: ResultSrc=10, ALUSrcA=01, ALUSrcB=10.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1.
- EXECUTEM: ALUOp=1; MulStart=1 on first cycle only.
- ALUWB: RegW=1, ResultSrc=00.
- MEMADR: ALUSrcB=01.
- MEMREAD: AdrSrc=1, ALUSrcB=01, MemReq=1.
- MEMWRITE: AdrSrc=1, MemW=1, ALUSrcB=01, MemReq=1.
- MEMWB: AdrSrc=1, RegW=1, ResultSrc=01, ALUSrcB=01.
- BRANCH: Branch=1, ResultSrc=10, ALUSrcB=01.

Outputs are a combinational decode of State plus MemReady; there are no X values on any output in any state.

Optional Feature:
MUL_EN.
- Defined: IsMul routes Op=00 to EXECUTEM for MUL_CYCLES cycles; MulStart pulses on the first cycle.
- Undefined: EXECUTEM and its counter are not built; IsMul is ignored (Op=00 decodes as normal data-processing); MulStart is tied 0.

Decomposition:
Package mainfsm_pkg holds:
- state enum (4-bit) and FAULT code constants;
- Op encodings (OP_DP=00, OP_MEM=01, OP_BR=10);
- ALUSrcA/B and ResultSrc select constants.

One sub-module, mem_wait_timer: counter, clear/enable, timeout flag, parametrised by MEM_TIMEOUT.

Test Plan:
- ADD reg, MemReady always 1 -> FETCH,DECODE,EXECUTER,ALUWB; RegW=1 in cycle 4; NextPC high exactly 1 cycle.
- LDR with MemReady low 3 cycles in MEMREAD -> MEMREAD held 4 cycles; MEMWB RegW=1, ResultSrc=01; Fault=00.
- STR, MEM_TIMEOUT=4, MemReady never high -> FAULT after 5 MEMWRITE cycles; Fault=01; MemW=0 thereafter; reset -> FETCH, Fault=00.
- Op=11 -> FAULT after DECODE; Fault=10; all controls 0 until reset.
- MUL_EN, MUL_CYCLES=3, IsMul=1 -> EXECUTEM 3 cycles; MulStart 1 cycle; then ALUWB. Without MUL_EN -> EXECUTER path, MulStart=0.
- Reset asserted during FETCH wait -> next cycle State=FETCH, counter=0, no IRWrite.

Source files
------------

// File: rtl/mainfsm_pkg.sv
// Shared types and encodings for the multicycle main control FSM.
package mainfsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_EXECUTEM = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_FAULT    = 4'd11
  } state_t;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
  localparam logic [1:0] FAULT_ILLOP   = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCA_REG  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // States that hold an outstanding memory request
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mainfsm_hs_mem_wait_timer.sv
// Wait-state counter for memory handshakes; flags a timeout when the
// request has been pending MEM_TIMEOUT cycles without MemReady.
// MEM_TIMEOUT = 0 disables the timeout (wait forever).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] count;

  // Count waiting cycles; a state change restarts the count
  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (enable)    count <= count + CW'(1);
  end

  // enable already implies MemReady is low, so a same-cycle ready wins
  assign timeout = (MEM_TIMEOUT != 0) && enable && (count == LIMIT);

endmodule

// File: rtl/mainfsm_hs.sv
// Main control FSM with memory request/ready handshake, bounded wait
// timeout and sticky fault reporting. Optional multiply execute state
// is built only when the macro MUL_EN is defined.
module mainfsm_hs
  import mainfsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int MUL_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       IsMul,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       MulStart,
  output logic [1:0] Fault,
  output logic [3:0] State
);

  state_t     state, state_next;
  logic [1:0] fault_q, fault_code;
  logic       wait_en, wait_clr, timeout;

  assign wait_en  = is_mem_state(state) && !MemReady;
  assign wait_clr = (state_next != state);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (wait_clr),
    .enable  (wait_en),
    .timeout (timeout)
  );

`ifdef MUL_EN
  logic [3:0] mul_cnt;
  logic       mul_done;
  logic       unused_funct;
  assign unused_funct = ^Funct[4:1];
  assign mul_done = (mul_cnt == 4'(MUL_CYCLES - 1));

  // Cycles spent in EXECUTEM; zero on the first cycle of each visit
  always_ff @(posedge clk) begin
    if (reset)                     mul_cnt <= '0;
    else if (state == S_EXECUTEM)  mul_cnt <= mul_cnt + 4'd1;
    else                           mul_cnt <= '0;
  end
`else
  logic unused_in;
  assign unused_in = IsMul ^ (^Funct[4:1]);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Sticky fault code captured on the transition into FAULT
  always_ff @(posedge clk) begin
    if (reset)                                       fault_q <= FAULT_NONE;
    else if (state != S_FAULT && state_next == S_FAULT) fault_q <= fault_code;
  end

  // Next-state logic and fault cause
  always_comb begin
    state_next = state;
    fault_code = FAULT_NONE;
    case (state)
      S_FETCH: begin
        if (MemReady)     state_next = S_DECODE;
        else if (timeout) begin state_next = S_FAULT; fault_code = FAULT_TIMEOUT; end
      end
      S_DECODE: begin
        case (Op)
          OP_DP: begin
`ifdef MUL_EN
            if (IsMul)          state_next = S_EXECUTEM;
            else if (Funct[5])  state_next = S_EXECUTEI;
            else                state_next = S_EXECUTER;
`else
            state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
`endif
          end
          OP_MEM:  state_next = S_MEMADR;
          OP_BR:   state_next = S_BRANCH;
          default: begin state_next = S_FAULT; fault_code = FAULT_ILLOP; end
        endcase
      end
      S_MEMADR: state_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (MemReady)     state_next = S_MEMWB;
        else if (timeout) begin state_next = S_FAULT; fault_code = FAULT_TIMEOUT; end
      end
      S_MEMWRITE: begin
        if (MemReady)     state_next = S_FETCH;
        else if (timeout) begin state_next = S_FAULT; fault_code = FAULT_TIMEOUT; end
      end
      S_MEMWB, S_ALUWB, S_BRANCH: state_next = S_FETCH;
      S_EXECUTER, S_EXECUTEI:     state_next = S_ALUWB;
`ifdef MUL_EN
      S_EXECUTEM: if (mul_done) state_next = S_ALUWB;
`endif
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FETCH;
    endcase
  end

  // Control decode from the current state and MemReady
  always_comb begin
    MemReq    = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_REG;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    MulStart  = 1'b0;
    case (state)
      S_FETCH: begin
        ResultSrc = RES_ALU; ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; MemReq = 1'b1;
        IRWrite = MemReady; NextPC = MemReady;
      end
      S_DECODE:   begin ResultSrc = RES_ALU; ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; end
      S_EXECUTER: ALUOp = 1'b1;
      S_EXECUTEI: begin ALUSrcB = SRCB_IMM; ALUOp = 1'b1; end
`ifdef MUL_EN
      S_EXECUTEM: begin ALUOp = 1'b1; MulStart = (mul_cnt == 4'd0); end
`endif
      S_ALUWB:    RegW = 1'b1;
      S_MEMADR:   ALUSrcB = SRCB_IMM;
      S_MEMREAD:  begin AdrSrc = 1'b1; ALUSrcB = SRCB_IMM; MemReq = 1'b1; end
      S_MEMWRITE: begin AdrSrc = 1'b1; MemW = 1'b1; ALUSrcB = SRCB_IMM; MemReq = 1'b1; end
      S_MEMWB:    begin AdrSrc = 1'b1; RegW = 1'b1; ResultSrc = RES_DATA; ALUSrcB = SRCB_IMM; end
      S_BRANCH:   begin Branch = 1'b1; ResultSrc = RES_ALU; ALUSrcB = SRCB_IMM; end
      default: ;
    endcase
  end

  assign Fault = fault_q;
  assign State = state;

endmodule

// File: tb/tb_mainfsm_hs.sv
// Scoreboard bench for mainfsm_hs: stimulus pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_mainfsm_hs;
  import mainfsm_pkg::*;

  logic       clk = 1'b0;
  logic       reset, IsMul, MemReady;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReq, IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, MulStart;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, Fault;
  logic [3:0] State;

  mainfsm_hs #(.MEM_TIMEOUT(4), .MUL_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .IsMul(IsMul),
    .MemReady(MemReady), .MemReq(MemReq), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .NextPC(NextPC),
    .RegW(RegW), .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp), .MulStart(MulStart),
    .Fault(Fault), .State(State)
  );

  always #5 clk = ~clk;

  // {MemReq,IRWrite,AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,RegW,MemW,Branch,ALUOp,MulStart}
  localparam logic [14:0] C_F_RDY = 15'b110_01_10_10_100000;
  localparam logic [14:0] C_F_WT  = 15'b100_01_10_10_000000;
  localparam logic [14:0] C_DEC   = 15'b000_01_10_10_000000;
  localparam logic [14:0] C_EXR   = 15'b000_00_00_00_000010;
  localparam logic [14:0] C_EXI   = 15'b000_00_01_00_000010;
  localparam logic [14:0] C_EXM0  = 15'b000_00_00_00_000011;
  localparam logic [14:0] C_EXM   = 15'b000_00_00_00_000010;
  localparam logic [14:0] C_AWB   = 15'b000_00_00_00_010000;
  localparam logic [14:0] C_MADR  = 15'b000_00_01_00_000000;
  localparam logic [14:0] C_MRD   = 15'b101_00_01_00_000000;
  localparam logic [14:0] C_MWR   = 15'b101_00_01_00_001000;
  localparam logic [14:0] C_MWB   = 15'b001_00_01_01_010000;
  localparam logic [14:0] C_BR    = 15'b000_00_01_10_000100;
  localparam logic [14:0] C_ZERO  = 15'b0;

  typedef struct {
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [1:0]  flt;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;
  logic [14:0] ctl_now;

  assign ctl_now = {MemReq, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                    NextPC, RegW, MemW, Branch, ALUOp, MulStart};

  // Drive one cycle of inputs and queue the expected outputs for that cycle
  task automatic st(input logic r, input logic rdy, input state_t es,
                    input logic [14:0] ec, input logic [1:0] ef);
    exp_t e;
    reset = r;
    MemReady = rdy;
    e.st = es; e.ctl = ec; e.flt = ef; e.id = step_id;
    exp_q.push_back(e);
    step_id++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (State !== e.st) begin
        n_fail++;
        $display("FAIL step%0d state: got %0d expected %0d", e.id, State, e.st);
      end
      n_checks++;
      if (ctl_now !== e.ctl) begin
        n_fail++;
        $display("FAIL step%0d controls: got %b expected %b", e.id, ctl_now, e.ctl);
      end
      n_checks++;
      if (Fault !== e.flt) begin
        n_fail++;
        $display("FAIL step%0d fault: got %b expected %b", e.id, Fault, e.flt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; MemReady = 1'b0; Op = 2'b00; Funct = 6'b0; IsMul = 1'b0;
    @(posedge clk);
    #1;
    // Reset held
    st(1, 0, S_FETCH, C_F_WT, 2'b00);

    // ADD register
    Op = 2'b00; Funct = 6'b000000; IsMul = 1'b0;
    st(0, 1, S_FETCH,    C_F_RDY, 2'b00);
    st(0, 1, S_DECODE,   C_DEC,   2'b00);
    st(0, 1, S_EXECUTER, C_EXR,   2'b00);
    st(0, 1, S_ALUWB,    C_AWB,   2'b00);

    // ADD immediate
    Funct = 6'b100000;
    st(0, 1, S_FETCH,    C_F_RDY, 2'b00);
    st(0, 1, S_DECODE,   C_DEC,   2'b00);
    st(0, 1, S_EXECUTEI, C_EXI,   2'b00);
    st(0, 1, S_ALUWB,    C_AWB,   2'b00);

    // LDR with three wait cycles
    Op = 2'b01; Funct = 6'b000001;
    st(0, 1, S_FETCH,   C_F_RDY, 2'b00);
    st(0, 1, S_DECODE,  C_DEC,   2'b00);
    st(0, 1, S_MEMADR,  C_MADR,  2'b00);
    for (int i = 0; i < 3; i++) st(0, 0, S_MEMREAD, C_MRD, 2'b00);
    st(0, 1, S_MEMREAD, C_MRD,   2'b00);
    st(0, 1, S_MEMWB,   C_MWB,   2'b00);

    // Branch
    Op = 2'b10; Funct = 6'b000000;
    st(0, 1, S_FETCH,  C_F_RDY, 2'b00);
    st(0, 1, S_DECODE, C_DEC,   2'b00);
    st(0, 1, S_BRANCH, C_BR,    2'b00);

    // STR completing after two wait cycles
    Op = 2'b01; Funct = 6'b000000;
    st(0, 1, S_FETCH,    C_F_RDY, 2'b00);
    st(0, 1, S_DECODE,   C_DEC,   2'b00);
    st(0, 1, S_MEMADR,   C_MADR,  2'b00);
    st(0, 0, S_MEMWRITE, C_MWR,   2'b00);
    st(0, 0, S_MEMWRITE, C_MWR,   2'b00);
    st(0, 1, S_MEMWRITE, C_MWR,   2'b00);

    // Multiply
    Op = 2'b00; Funct = 6'b000000; IsMul = 1'b1;
    st(0, 1, S_FETCH,  C_F_RDY, 2'b00);
    st(0, 1, S_DECODE, C_DEC,   2'b00);
`ifdef MUL_EN
    st(0, 1, S_EXECUTEM, C_EXM0, 2'b00);
    st(0, 1, S_EXECUTEM, C_EXM,  2'b00);
    st(0, 1, S_EXECUTEM, C_EXM,  2'b00);
`else
    st(0, 1, S_EXECUTER, C_EXR,  2'b00);
`endif
    st(0, 1, S_ALUWB,  C_AWB,   2'b00);

    // STR that never gets MemReady: timeout after five MEMWRITE cycles
    Op = 2'b01; Funct = 6'b000000; IsMul = 1'b0;
    st(0, 1, S_FETCH,  C_F_RDY, 2'b00);
    st(0, 1, S_DECODE, C_DEC,   2'b00);
    st(0, 1, S_MEMADR, C_MADR,  2'b00);
    for (int i = 0; i < 5; i++) st(0, 0, S_MEMWRITE, C_MWR, 2'b00);
    st(0, 0, S_FAULT, C_ZERO, 2'b01);
    st(0, 1, S_FAULT, C_ZERO, 2'b01);
    st(1, 1, S_FAULT, C_ZERO, 2'b01);
    st(0, 0, S_FETCH, C_F_WT, 2'b00);

    // Illegal opcode
    Op = 2'b11;
    st(0, 1, S_FETCH,  C_F_RDY, 2'b00);
    st(0, 1, S_DECODE, C_DEC,   2'b00);
    st(0, 1, S_FAULT,  C_ZERO,  2'b10);
    st(0, 0, S_FAULT,  C_ZERO,  2'b10);
    st(1, 0, S_FAULT,  C_ZERO,  2'b10);
    st(0, 0, S_FETCH,  C_F_WT,  2'b00);

    // Reset during a fetch wait restarts the wait count
    Op = 2'b00;
    st(0, 0, S_FETCH, C_F_WT, 2'b00);
    st(0, 0, S_FETCH, C_F_WT, 2'b00);
    st(1, 0, S_FETCH, C_F_WT, 2'b00);
    for (int i = 0; i < 5; i++) st(0, 0, S_FETCH, C_F_WT, 2'b00);
    st(0, 1, S_FAULT, C_ZERO, 2'b01);
    st(1, 1, S_FAULT, C_ZERO, 2'b01);
    st(0, 1, S_FETCH, C_F_RDY, 2'b00);
    st(0, 1, S_DECODE, C_DEC,  2'b00);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
